// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared control-unit types for the multi-cycle RV32I core: FSM states,
// opcode constants and the ImmSrc / ALUOp / ALU-control encodings that the
// immediate extender and ALU also consume.
// Optional build macro: CTRL_ILLEGAL_TRAP_EN adds the TRAP state.
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWRITE,
        MEMWB,
        EXECUTER,
        EXECUTEI,
        ALUWB,
        BEQ,
        JAL
`ifdef CTRL_ILLEGAL_TRAP_EN
        , TRAP
`endif
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_t;

    // Immediate format follows the opcode alone, independent of FSM state
    function automatic imm_src_t imm_src_for(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

    // funct3 values the ALU decoder implements
    function automatic logic funct3_supported(input logic [2:0] funct3);
        return (funct3 == 3'b000) || (funct3 == 3'b010) ||
               (funct3 == 3'b110) || (funct3 == 3'b111);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_alu_decoder.sv
// ALU decoder: maps ALUOp plus funct3/funct7b5/op[5] to the ALU control code.
// Unsupported funct3 values fall back to add.
import ctrl_pkg::*;

module alu_decoder (
    input  alu_op_t     alu_op,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        op5,
    output alu_ctrl_t   alu_control
);

    // Combinational decode; R-type sub needs both op[5] and funct7[5]
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            default: begin
                case (funct3)
                    3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multi-cycle RV32I core. Sequences fetch, decode,
// execute, memory and writeback; fetch and memory states stall on mem_ready.
// Optional build macro: CTRL_ILLEGAL_TRAP_EN adds illegal_instr and a TRAP
// state entered on unsupported op/funct3 and left only through rst_n.
import ctrl_pkg::*;

module multicycle_ctrl_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic [2:0] alu_control,
`ifdef CTRL_ILLEGAL_TRAP_EN
    output logic       illegal_instr,
`endif
    output logic       reg_write
);

    localparam state_t RESET_STATE = FETCH;

    state_t    state_q, state_d;
    alu_op_t   alu_op;
    alu_ctrl_t alu_ctrl;
    logic      branch;
    logic      pc_update;

    // State register; reset pulls straight back to fetch, killing any write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RESET_STATE;
        else        state_q <= state_d;
    end

    // Next-state and Moore outputs; everything defaults to idle first
    always_comb begin
        state_d    = state_q;
        pc_update  = 1'b0;
        branch     = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = ALUOP_ADD;
`ifdef CTRL_ILLEGAL_TRAP_EN
        illegal_instr = 1'b0;
`endif
        case (state_q)
            FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_update  = mem_ready;
                if (mem_ready) state_d = DECODE;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_RTYPE:          state_d = EXECUTER;
                    OP_ITYPE:          state_d = EXECUTEI;
                    OP_BRANCH:         state_d = BEQ;
                    OP_JAL:            state_d = JAL;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    default:           state_d = TRAP;
`else
                    default:           state_d = FETCH;
`endif
                endcase
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                adr_src = 1'b1;
                if (mem_ready) state_d = MEMWB;
            end
            MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) state_d = FETCH;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_d    = FETCH;
            end
            EXECUTER, EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = (state_q == EXECUTEI) ? 2'b01 : 2'b00;
                alu_op    = ALUOP_FUNCT;
                state_d   = ALUWB;
`ifdef CTRL_ILLEGAL_TRAP_EN
                if (!funct3_supported(funct3)) state_d = TRAP;
`endif
            end
            ALUWB: begin
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = ALUOP_SUB;
                branch    = 1'b1;
                state_d   = FETCH;
            end
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
                state_d   = ALUWB;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            TRAP: begin
                illegal_instr = 1'b1;
                state_d       = TRAP;
            end
`endif
            default: state_d = FETCH;
        endcase
    end

    assign pc_write    = (branch & zero) | pc_update;
    assign imm_src     = imm_src_for(op);
    assign alu_control = alu_ctrl;

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (op[5]),
        .alu_control (alu_ctrl)
    );

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: the driver applies one input
// vector per cycle and queues the hand-computed output vector; the monitor
// pops and compares on the falling edge.
module tb_multicycle_ctrl_fsm;

    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] RT   = 7'b0110011;
    localparam logic [6:0] IT   = 7'b0010011;
    localparam logic [6:0] BR   = 7'b1100011;
    localparam logic [6:0] JL   = 7'b1101111;
    localparam logic [6:0] BAD  = 7'b0000000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = '0;
    logic [2:0] funct3 = '0;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;
    logic       ill;

    int unsigned tests = 0;
    int unsigned failed = 0;

    logic [16:0] exp_q[$];
    string       name_q[$];
    logic [16:0] act, expv;
    string       nm;

    multicycle_ctrl_fsm dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op          (op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .pc_write    (pc_write),
        .adr_src     (adr_src),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .result_src  (result_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .imm_src     (imm_src),
        .alu_control (alu_control),
`ifdef CTRL_ILLEGAL_TRAP_EN
        .illegal_instr (ill),
`endif
        .reg_write   (reg_write)
    );

`ifndef CTRL_ILLEGAL_TRAP_EN
    assign ill = 1'b0;
`endif

    always #5 clk = ~clk;

    // Expected vector: {ill, pcw, adr, mw, irw, rs, a, b, imm, alu, rw}
    function automatic logic [16:0] ev(input logic pcw, input logic adr,
                                       input logic mw, input logic irw,
                                       input logic [1:0] rs, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] imm,
                                       input logic [2:0] alu, input logic rw,
                                       input logic il = 1'b0);
        return {il, pcw, adr, mw, irw, rs, a, b, imm, alu, rw};
    endfunction

    // One cycle of stimulus: drive just after the rising edge, queue expectation
    task automatic cyc(input string n, input logic [6:0] o, input logic [2:0] f3,
                       input logic f7, input logic z, input logic mr,
                       input logic rn, input logic [16:0] e);
        @(posedge clk);
        #1;
        op = o; funct3 = f3; funct7b5 = f7; zero = z; mem_ready = mr; rst_n = rn;
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    // Full ALU instruction: fetch, decode, execute, writeback (imm_src=I)
    task automatic alu_instr(input string n, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input logic [1:0] b, input logic [2:0] alu);
        cyc({n, "_fetch"},  o, f3, f7, 0, 1, 1, ev(1,0,0,1,2'b10,2'b00,2'b10,2'b00,3'b000,0));
        cyc({n, "_decode"}, o, f3, f7, 0, 1, 1, ev(0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0));
        cyc({n, "_exec"},   o, f3, f7, 0, 1, 1, ev(0,0,0,0,2'b00,2'b10,b,2'b00,alu,0));
        cyc({n, "_aluwb"},  o, f3, f7, 0, 1, 1, ev(0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,1));
    endtask

    // Monitor: compares the queued expectation against live outputs
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            expv = exp_q.pop_front();
            nm   = name_q.pop_front();
            act  = {ill, pc_write, adr_src, mem_write, ir_write, result_src,
                    alu_src_a, alu_src_b, imm_src, alu_control, reg_write};
            tests++;
            if (act !== expv) begin
                failed++;
                $display("FAIL %s: got %b expected %b", nm, act, expv);
            end
        end
    end

    initial begin
        // Reset and fetch stall
        cyc("reset",      BAD, 0, 0, 0, 0, 0, ev(0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
        cyc("fetch_hold", BAD, 0, 0, 0, 0, 1, ev(0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
        cyc("fetch_hold", BAD, 0, 0, 0, 0, 1, ev(0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));

        // lw
        cyc("lw_fetch",   LW, 0, 0, 0, 1, 1, ev(1,0,0,1,2'b10,2'b00,2'b10,2'b00,3'b000,0));
        cyc("lw_decode",  LW, 0, 0, 0, 1, 1, ev(0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0));
        cyc("lw_memadr",  LW, 0, 0, 0, 1, 1, ev(0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0));
        cyc("lw_memread", LW, 0, 0, 0, 1, 1, ev(0,1,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0));
        cyc("lw_memwb",   LW, 0, 0, 0, 1, 1, ev(0,0,0,0,2'b01,2'b00,2'b00,2'b00,3'b000,1));

        // sw with three wait cycles
        cyc("sw_fetch",   SW, 0, 0, 0, 1, 1, ev(1,0,0,1,2'b10,2'b00,2'b10,2'b01,3'b000,0));
        cyc("sw_decode",  SW, 0, 0, 0, 1, 1, ev(0,0,0,0,2'b00,2'b01,2'b01,2'b01,3'b000,0));
        cyc("sw_memadr",  SW, 0, 0, 0, 0, 1, ev(0,0,0,0,2'b00,2'b10,2'b01,2'b01,3'b000,0));
        for (int i = 0; i < 3; i++)
            cyc("sw_wait",SW, 0, 0, 0, 0, 1, ev(0,1,1,0,2'b00,2'b00,2'b00,2'b01,3'b000,0));
        cyc("sw_write",   SW, 0, 0, 0, 1, 1, ev(0,1,1,0,2'b00,2'b00,2'b00,2'b01,3'b000,0));
        cyc("sw_done",    SW, 0, 0, 0, 0, 1, ev(0,0,0,0,2'b10,2'b00,2'b10,2'b01,3'b000,0));

        // ALU instructions
        alu_instr("r_sub",   RT, 3'b000, 1, 2'b00, 3'b001);
        alu_instr("r_add",   RT, 3'b000, 0, 2'b00, 3'b000);
        alu_instr("r_slt",   RT, 3'b010, 0, 2'b00, 3'b101);
        alu_instr("r_and",   RT, 3'b111, 0, 2'b00, 3'b010);
        alu_instr("i_addi",  IT, 3'b000, 1, 2'b01, 3'b000);
        alu_instr("i_ori",   IT, 3'b110, 0, 2'b01, 3'b011);
`ifndef CTRL_ILLEGAL_TRAP_EN
        alu_instr("i_f3unk", IT, 3'b001, 0, 2'b01, 3'b000);
`endif

        // beq taken / not taken
        cyc("beq1_fetch", BR, 0, 0, 1, 1, 1, ev(1,0,0,1,2'b10,2'b00,2'b10,2'b10,3'b000,0));
        cyc("beq1_decode",BR, 0, 0, 1, 1, 1, ev(0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000,0));
        cyc("beq1_beq",   BR, 0, 0, 1, 1, 1, ev(1,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001,0));
        cyc("beq0_fetch", BR, 0, 0, 0, 1, 1, ev(1,0,0,1,2'b10,2'b00,2'b10,2'b10,3'b000,0));
        cyc("beq0_decode",BR, 0, 0, 0, 1, 1, ev(0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000,0));
        cyc("beq0_beq",   BR, 0, 0, 0, 1, 1, ev(0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001,0));

        // jal
        cyc("jal_fetch",  JL, 0, 0, 0, 1, 1, ev(1,0,0,1,2'b10,2'b00,2'b10,2'b11,3'b000,0));
        cyc("jal_decode", JL, 0, 0, 0, 1, 1, ev(0,0,0,0,2'b00,2'b01,2'b01,2'b11,3'b000,0));
        cyc("jal_jal",    JL, 0, 0, 0, 1, 1, ev(1,0,0,0,2'b00,2'b01,2'b10,2'b11,3'b000,0));
        cyc("jal_aluwb",  JL, 0, 0, 0, 1, 1, ev(0,0,0,0,2'b00,2'b00,2'b00,2'b11,3'b000,1));

        // unsupported opcode
        cyc("bad_fetch",  BAD, 0, 0, 0, 1, 1, ev(1,0,0,1,2'b10,2'b00,2'b10,2'b00,3'b000,0));
        cyc("bad_decode", BAD, 0, 0, 0, 1, 1, ev(0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0));
`ifdef CTRL_ILLEGAL_TRAP_EN
        cyc("trap",       BAD, 0, 0, 1, 1, 1, ev(0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,1));
        cyc("trap_hold",  BAD, 0, 0, 1, 1, 1, ev(0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,1));
        cyc("trap_reset", BAD, 0, 0, 0, 0, 0, ev(0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
`else
        cyc("bad_nop",    BAD, 0, 0, 0, 0, 1, ev(0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
`endif

        // Reset asserted mid-MEMWRITE
        cyc("rs_fetch",   SW, 0, 0, 0, 1, 1, ev(1,0,0,1,2'b10,2'b00,2'b10,2'b01,3'b000,0));
        cyc("rs_decode",  SW, 0, 0, 0, 1, 1, ev(0,0,0,0,2'b00,2'b01,2'b01,2'b01,3'b000,0));
        cyc("rs_memadr",  SW, 0, 0, 0, 0, 1, ev(0,0,0,0,2'b00,2'b10,2'b01,2'b01,3'b000,0));
        cyc("rs_memwr",   SW, 0, 0, 0, 0, 1, ev(0,1,1,0,2'b00,2'b00,2'b00,2'b01,3'b000,0));
        cyc("rs_assert",  SW, 0, 0, 0, 0, 0, ev(0,0,0,0,2'b10,2'b00,2'b10,2'b01,3'b000,0));
        cyc("rs_release", SW, 0, 0, 0, 0, 1, ev(0,0,0,0,2'b10,2'b00,2'b10,2'b01,3'b000,0));
        cyc("rs_hold",    SW, 0, 0, 0, 0, 1, ev(0,0,0,0,2'b10,2'b00,2'b10,2'b01,3'b000,0));

        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
